// File: rtl/glb_cfg_reg_responder.sv
// GLB register-configuration responder: word-addressed register bank with a fixed-latency read pipeline.
// Define GLB_CFG_REG_ERR_EN to add an out-of-range access status register at index NUM_REGS.
module glb_cfg_reg_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int RD_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_clk_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_clk_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int REG_IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS);

    logic [IDX_W-1:0]      wrIdx;
    logic [IDX_W-1:0]      rdIdx;
    logic                  wrAccept;
    logic                  rdAccept;
    logic                  wrBankHit;
    logic                  rdBankHit;
    logic [DATA_WIDTH-1:0] rdWord;
    logic                  unusedAddrBits;

    logic [DATA_WIDTH-1:0] regs_q      [NUM_REGS];
    logic                  validPipe_q [RD_LATENCY+1];
    logic [DATA_WIDTH-1:0] dataPipe_q  [RD_LATENCY+1];

    assign wrIdx          = wr_addr[ADDR_WIDTH-1:2];
    assign rdIdx          = rd_addr[ADDR_WIDTH-1:2];
    assign wrAccept       = wr_en & wr_clk_en;
    assign rdAccept       = rd_en & rd_clk_en;
    assign wrBankHit      = wrIdx < LAST_IDX;
    assign rdBankHit      = rdIdx < LAST_IDX;
    assign unusedAddrBits = ^{wr_addr[1:0], rd_addr[1:0]};

`ifdef GLB_CFG_REG_ERR_EN
    logic [7:0]            errCnt_q;
    logic [7:0]            errCnt_d;
    logic                  errSticky_q;
    logic                  errSticky_d;
    logic                  wrStatHit;
    logic                  rdStatHit;
    logic                  wrMiss;
    logic                  rdMiss;
    logic [1:0]            missCount;
    logic [8:0]            cntSum;
    logic [DATA_WIDTH-1:0] statusWord;

    assign wrStatHit  = wrIdx == LAST_IDX;
    assign rdStatHit  = rdIdx == LAST_IDX;
    assign wrMiss     = wrAccept & (wrIdx > LAST_IDX);
    assign rdMiss     = rdAccept & (rdIdx > LAST_IDX);
    assign missCount  = {1'b0, wrMiss} + {1'b0, rdMiss};
    assign cntSum     = {1'b0, errCnt_q} + {7'b0, missCount};
    assign statusWord = DATA_WIDTH'({errSticky_q, errCnt_q});

    // A write to the status address clears it and wins over any same-cycle miss increment.
    always_comb begin
        errCnt_d    = errCnt_q;
        errSticky_d = errSticky_q;
        if (wrAccept && wrStatHit) begin
            errCnt_d    = '0;
            errSticky_d = 1'b0;
        end else if (missCount != 2'd0) begin
            errCnt_d    = cntSum[8] ? 8'hFF : cntSum[7:0];
            errSticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            errCnt_q    <= '0;
            errSticky_q <= 1'b0;
        end else begin
            errCnt_q    <= errCnt_d;
            errSticky_q <= errSticky_d;
        end
    end
`endif

    always_comb begin
        rdWord = '0;
        if (rdBankHit) begin
            rdWord = regs_q[rdIdx[REG_IW-1:0]];
        end
`ifdef GLB_CFG_REG_ERR_EN
        if (rdStatHit) begin
            rdWord = statusWord;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (wrAccept && wrBankHit) begin
            regs_q[wrIdx[REG_IW-1:0]] <= wr_data;
        end
    end

    // Stage 0 captures the bank before this edge's write lands, giving read-before-write ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= RD_LATENCY; k++) begin
                validPipe_q[k] <= 1'b0;
                dataPipe_q[k]  <= '0;
            end
        end else begin
            validPipe_q[0] <= rdAccept;
            dataPipe_q[0]  <= rdAccept ? rdWord : '0;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                validPipe_q[k] <= validPipe_q[k-1];
                dataPipe_q[k]  <= dataPipe_q[k-1];
            end
        end
    end

    assign rd_data_valid = validPipe_q[RD_LATENCY];
    assign rd_data       = validPipe_q[RD_LATENCY] ? dataPipe_q[RD_LATENCY] : '0;

endmodule

// File: tb/tb_glb_cfg_reg_responder.sv
// Scoreboard bench for glb_cfg_reg_responder: a driver pushes modelled read results, a monitor checks strobes.
// The status-register model follows GLB_CFG_REG_ERR_EN when it is defined.
module tb_glb_cfg_reg_responder;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int LAT = 2;
    localparam logic [DW-1:0] RV = 32'h0000_0000;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          wr_clk_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          rd_clk_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;

    glb_cfg_reg_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RD_LATENCY(LAT), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_clk_en(wr_clk_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_clk_en(rd_clk_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        logic [AW-1:0] addr;
    } exp_t;
    exp_t expQ[$];

    // Reference model: plain array of register values plus the status counter as integers.
    logic [DW-1:0] modelRegs [NR];
    int            statCnt;
    bit            statSticky;

    task automatic modelReset();
        for (int i = 0; i < NR; i++) modelRegs[i] = RV;
        statCnt    = 0;
        statSticky = 0;
    endtask

    function automatic logic [DW-1:0] modelRead(input int idx);
        if (idx < NR) return modelRegs[idx];
`ifdef GLB_CFG_REG_ERR_EN
        if (idx == NR) return DW'(statCnt) | (statSticky ? 32'h100 : 32'h0);
`endif
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    // One call = one clock cycle of requests; the model is updated as the DUT should be at the next edge.
    task automatic applyStimulus(input bit we, input bit wce, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input bit re, input bit rce,
                                 input logic [AW-1:0] ra);
        int   wIdx;
        int   rIdx;
        int   misses;
        exp_t e;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        wr_en     = we;
        wr_clk_en = wce;
        wr_addr   = wa;
        wr_data   = wd;
        rd_en     = re;
        rd_clk_en = rce;
        rd_addr   = ra;
        wIdx   = int'(wa) / 4;
        rIdx   = int'(ra) / 4;
        misses = 0;
        if (re && rce) begin
            e.data = modelRead(rIdx);
            e.due  = cyc + 1 + LAT;
            e.addr = ra;
            expQ.push_back(e);
            if (rIdx > NR) misses++;
        end
        if (we && wce && wIdx > NR) misses++;
`ifdef GLB_CFG_REG_ERR_EN
        if (we && wce && wIdx == NR) begin
            statCnt    = 0;
            statSticky = 0;
        end else if (misses > 0) begin
            statCnt    = (statCnt + misses > 255) ? 255 : statCnt + misses;
            statSticky = 1;
        end
`endif
        if (we && wce && wIdx < NR) modelRegs[wIdx] = wd;
    endtask

    task automatic readReq(input logic [AW-1:0] a);
        applyStimulus(0, 0, '0, '0, 1, 1, a);
    endtask

    task automatic writeReq(input logic [AW-1:0] a, input logic [DW-1:0] d);
        applyStimulus(1, 1, a, d, 0, 0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0);
    endtask

    // Reset sampled at the next edge kills every read not yet presented at that edge.
    task automatic pulseReset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_clk_en = 1'b0;
        rd_en     = 1'b0;
        rd_clk_en = 1'b0;
        while (expQ.size() > 0 && expQ[$].due > cyc) void'(expQ.pop_back());
        modelReset();
    endtask

    // Monitor: pops the scoreboard on each strobe and checks data and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (rd_data_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_valid at cycle %0d: got valid with data 0x%08h, expected none",
                             cyc, rd_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("rd_data[0x%03h]", e.addr), rd_data, e.data);
                    checkOutput($sformatf("rd_latency[0x%03h]", e.addr), DW'(cyc), DW'(e.due));
                end
            end else begin
                checkOutput("rd_valid_known", {31'b0, rd_data_valid}, 32'h0);
                checkOutput("rd_data_idle", rd_data, '0);
                if (expQ.size() > 0 && expQ[0].due <= cyc) begin
                    e = expQ.pop_front();
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL missing_valid[0x%03h] at cycle %0d: got no strobe, expected one at cycle %0d",
                             e.addr, cyc, e.due);
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_clk_en = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_clk_en = 1'b0;
        rd_addr   = '0;
        modelReset();
        repeat (3) @(posedge clk);

        for (int i = 0; i < NR; i++) readReq(AW'(i * 4));

        writeReq(12'h008, 32'hDEAD_BEEF);
        readReq(12'h008);
        applyStimulus(1, 0, 12'h008, 32'h1111_1111, 0, 0, '0);
        readReq(12'h008);
        applyStimulus(0, 0, '0, '0, 1, 0, 12'h00C);
        applyStimulus(1, 0, 12'h00C, 32'h2222_2222, 1, 0, 12'h00C);

        applyStimulus(1, 1, 12'h010, 32'h1234_5678, 1, 1, 12'h010);
        readReq(12'h010);
        applyStimulus(1, 1, 12'h014, 32'hCAFE_0001, 1, 1, 12'h018);

        for (int i = 0; i < 8; i++) writeReq(AW'(i * 4), 32'hA500_0000 + DW'(i * 32'h0101));
        for (int i = 0; i < 8; i++) readReq(AW'(i * 4 + (i % 4)));
        readReq(12'h040);
        readReq(12'hFFC);
        idle(LAT + 1);

        readReq(12'h000);
        readReq(12'h004);
        pulseReset();
        idle(LAT + 2);
        readReq(12'h008);
        readReq(12'h000);
        idle(LAT + 1);

        for (int i = 0; i < 3; i++) writeReq(12'h080, 32'h5555_0000 + DW'(i));
        readReq(12'h080);
        readReq(12'h080);
        readReq(12'h040);
        writeReq(12'h040, 32'hFFFF_FFFF);
        readReq(12'h040);
        for (int i = 0; i < 300; i++) readReq(12'h080 + AW'(i % 64) * 4);
        readReq(12'h040);
        applyStimulus(1, 1, 12'h040, 32'h0, 1, 1, 12'h040);
        readReq(12'h040);
        applyStimulus(1, 1, 12'h0C0, 32'h0, 1, 1, 12'h100);
        readReq(12'h040);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulseReset();
            end else begin
                wa = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, NR) * 4 + $urandom_range(0, 3))
                                                 : AW'($urandom);
                ra = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, NR) * 4 + $urandom_range(0, 3))
                                                 : AW'($urandom);
                applyStimulus(bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, wa, DW'($urandom),
                              bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, ra);
            end
        end

        idle(LAT + 3);
        @(negedge clk);
        checkOutput("queue_drained", DW'(expQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
